fetch_unit: RTL and testbench

- Byte-serial instruction fetch stage for the 6502-compatible core. Sits between the program-counter/branch logic and decode.
- Reads opcode and operand bytes from the 8-bit memory port starting at its internal fetch PC. Determines instruction length from the opcode.
- Presents one assembled instruction (opcode, 16-bit operand, length, PC) to decode over a valid/ready handshake.
- Redirects on flush (taken branch / jump) from downstream.

---
 rtl/nes_cpu_pkg.sv | 28 ++
 rtl/instr_len_decoder.sv | 65 ++++++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 478 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_cpu_pkg.sv
// Shared types and constants for the 6502-compatible core.
// The fetch stage and the decoder both pull their types from here.
package nes_cpu_pkg;

  localparam int MEM_ADDR_SIZE = 16;
  localparam logic [MEM_ADDR_SIZE-1:0] BOOT_ADDR = 16'hFFFC;

  typedef logic [1:0] instr_len_t;

  localparam instr_len_t LEN_1 = 2'd1;
  localparam instr_len_t LEN_2 = 2'd2;
  localparam instr_len_t LEN_3 = 2'd3;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_OUT,
    S_DRAIN
  } fetch_state_e;

  typedef struct packed {
    logic [7:0]               opcode;
    logic [15:0]              operand;
    instr_len_t               len;
    logic [MEM_ADDR_SIZE-1:0] pc;
  } fetch_instr_t;

endpackage

// File: rtl/instr_len_decoder.sv
// Combinational 6502 opcode -> instruction length (1..3 bytes).
// Undocumented opcodes report length 1.
module instr_len_decoder
  import nes_cpu_pkg::*;
(
  input  logic [7:0] opcode_i,
  output instr_len_t len_o
);

  logic [2:0] aaa;
  logic [2:0] bbb;
  logic [1:0] cc;

  // Opcodes split as aaa_bbb_cc: cc selects the group, bbb the addressing mode.
  assign aaa = opcode_i[7:5];
  assign bbb = opcode_i[4:2];
  assign cc  = opcode_i[1:0];

  always_comb begin
    len_o = LEN_1;
    case (cc)
      2'b01: begin
        case (bbb)
          3'b011, 3'b110, 3'b111: len_o = LEN_3;
          3'b010:                 len_o = (aaa == 3'b100) ? LEN_1 : LEN_2;
          default:                len_o = LEN_2;
        endcase
      end
      2'b10: begin
        case (bbb)
          3'b000:         len_o = (aaa == 3'b101) ? LEN_2 : LEN_1;
          3'b001, 3'b101: len_o = LEN_2;
          3'b011:         len_o = LEN_3;
          3'b111:         len_o = (aaa == 3'b100) ? LEN_1 : LEN_3;
          default:        len_o = LEN_1;
        endcase
      end
      2'b00: begin
        case (bbb)
          3'b000: begin
            if (aaa == 3'b001)
              len_o = LEN_3;
            else if (aaa >= 3'b101)
              len_o = LEN_2;
            else
              len_o = LEN_1;
          end
          3'b001: begin
            if ((aaa == 3'b001) || (aaa >= 3'b100))
              len_o = LEN_2;
            else
              len_o = LEN_1;
          end
          3'b011:  len_o = (aaa != 3'b000) ? LEN_3 : LEN_1;
          3'b100:  len_o = LEN_2;
          3'b101:  len_o = ((aaa == 3'b100) || (aaa == 3'b101)) ? LEN_2 : LEN_1;
          3'b111:  len_o = (aaa == 3'b101) ? LEN_3 : LEN_1;
          default: len_o = LEN_1;
        endcase
      end
      default: len_o = LEN_1;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Byte-serial 6502 instruction fetch: one memory request at a time, assembles
// opcode + operand bytes and hands the instruction to decode over valid/ready.
module fetch_unit
  import nes_cpu_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_SIZE,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [7:0]        instr_opcode_o,
  output logic [15:0]       instr_operand_o,
  output logic [1:0]        instr_len_o,
  output logic [ADDR_W-1:0] instr_pc_o
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] fetch_pc_d;
  logic [1:0]        byte_idx_q;
  fetch_instr_t      instr_q;

  instr_len_t        lut_len;
  instr_len_t        cur_len;
  logic              last_byte;

  instr_len_decoder u_len_dec (
    .opcode_i (mem_rdata_i),
    .len_o    (lut_len)
  );

  // The opcode byte defines the length; later bytes use the captured value.
  assign cur_len    = (byte_idx_q == 2'd0) ? lut_len : instr_q.len;
  assign last_byte  = ((byte_idx_q + 2'd1) == cur_len);
  assign fetch_pc_d = fetch_pc_q + ADDR_W'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_REQ;
      fetch_pc_q <= ADDR_W'(BOOT_ADDR);
      byte_idx_q <= 2'd0;
      instr_q    <= '0;
    end else if (flush_i) begin
      fetch_pc_q <= flush_pc_i;
      byte_idx_q <= 2'd0;
      // Any request still in flight must be drained before a new one is issued.
      case (state_q)
        S_REQ:   state_q <= S_DRAIN;
        S_WAIT:  state_q <= mem_rvalid_i ? S_REQ : S_DRAIN;
        S_DRAIN: state_q <= mem_rvalid_i ? S_REQ : S_DRAIN;
        default: state_q <= S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_rvalid_i) begin
            case (byte_idx_q)
              2'd0: begin
                instr_q.opcode  <= mem_rdata_i;
                instr_q.pc      <= fetch_pc_q;
                instr_q.len     <= lut_len;
                instr_q.operand <= 16'h0000;
              end
              2'd1:    instr_q.operand[7:0]  <= mem_rdata_i;
              default: instr_q.operand[15:8] <= mem_rdata_i;
            endcase
            fetch_pc_q <= fetch_pc_d;
            if (last_byte) begin
              byte_idx_q <= 2'd0;
              state_q    <= S_OUT;
            end else begin
              byte_idx_q <= byte_idx_q + 2'd1;
              state_q    <= S_REQ;
            end
          end
        end
        S_OUT: begin
          if (instr_ready_i)
            state_q <= S_REQ;
        end
        S_DRAIN: begin
          if (mem_rvalid_i)
            state_q <= S_REQ;
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

  // Reset parks the FSM in S_REQ, so the request strobe is masked while rst_i is high.
  assign mem_req_o       = (state_q == S_REQ) & ~rst_i;
  assign mem_addr_o      = mem_req_o ? fetch_pc_q : '0;
  assign instr_valid_o   = (state_q == S_OUT);
  assign instr_opcode_o  = instr_q.opcode;
  assign instr_operand_o = instr_q.operand;
  assign instr_len_o     = instr_q.len;
  assign instr_pc_o      = instr_q.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized streams
// compared against a table-driven instruction model over a byte memory.
module tb_fetch_unit;
  import nes_cpu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic [15:0] flush_pc_i;
  logic        mem_req_o;
  logic [15:0] mem_addr_o;
  logic        mem_rvalid_i;
  logic [7:0]  mem_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [7:0]  instr_opcode_o;
  logic [15:0] instr_operand_o;
  logic [1:0]  instr_len_o;
  logic [15:0] instr_pc_o;

  always #5 clk_i = ~clk_i;

  fetch_unit #(.ADDR_W(16), .DATA_W(8)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .flush_i         (flush_i),
    .flush_pc_i      (flush_pc_i),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_rvalid_i    (mem_rvalid_i),
    .mem_rdata_i     (mem_rdata_i),
    .instr_valid_o   (instr_valid_o),
    .instr_ready_i   (instr_ready_i),
    .instr_opcode_o  (instr_opcode_o),
    .instr_operand_o (instr_operand_o),
    .instr_len_o     (instr_len_o),
    .instr_pc_o      (instr_pc_o)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [0:65535];
  int          lat = 1;
  logic [15:0] req_log [$];
  int          rsp_cnt = 0;
  logic [15:0] rsp_addr = 16'h0;

  // Documented 6502 opcodes by length; everything else is one byte.
  logic [7:0] len2_tab [74] = '{
    8'h01, 8'h05, 8'h09, 8'h11, 8'h15, 8'h21, 8'h25, 8'h29, 8'h31, 8'h35,
    8'h41, 8'h45, 8'h49, 8'h51, 8'h55, 8'h61, 8'h65, 8'h69, 8'h71, 8'h75,
    8'h81, 8'h85, 8'h91, 8'h95, 8'hA1, 8'hA5, 8'hA9, 8'hB1, 8'hB5,
    8'hC1, 8'hC5, 8'hC9, 8'hD1, 8'hD5, 8'hE1, 8'hE5, 8'hE9, 8'hF1, 8'hF5,
    8'hA2, 8'h06, 8'h26, 8'h46, 8'h66, 8'h86, 8'hA6, 8'hC6, 8'hE6,
    8'h16, 8'h36, 8'h56, 8'h76, 8'h96, 8'hB6, 8'hD6, 8'hF6,
    8'hA0, 8'hC0, 8'hE0, 8'h24, 8'h84, 8'hA4, 8'hC4, 8'hE4,
    8'h10, 8'h30, 8'h50, 8'h70, 8'h90, 8'hB0, 8'hD0, 8'hF0, 8'h94, 8'hB4
  };
  logic [7:0] len3_tab [48] = '{
    8'h20, 8'h2C, 8'h4C, 8'h6C, 8'h8C, 8'hAC, 8'hCC, 8'hEC, 8'hBC,
    8'h0D, 8'h19, 8'h1D, 8'h2D, 8'h39, 8'h3D, 8'h4D, 8'h59, 8'h5D,
    8'h6D, 8'h79, 8'h7D, 8'h8D, 8'h99, 8'h9D, 8'hAD, 8'hB9, 8'hBD,
    8'hCD, 8'hD9, 8'hDD, 8'hED, 8'hF9, 8'hFD,
    8'h0E, 8'h2E, 8'h4E, 8'h6E, 8'h8E, 8'hAE, 8'hCE, 8'hEE,
    8'h1E, 8'h3E, 8'h5E, 8'h7E, 8'hDE, 8'hFE, 8'hBE
  };

  function automatic instr_len_t len_ref(logic [7:0] op);
    instr_len_t l;
    l = 2'd1;
    foreach (len2_tab[i]) if (len2_tab[i] == op) l = 2'd2;
    foreach (len3_tab[i]) if (len3_tab[i] == op) l = 2'd3;
    return l;
  endfunction

  function automatic fetch_instr_t model_instr(logic [15:0] pc);
    fetch_instr_t r;
    logic [15:0] a1;
    logic [15:0] a2;
    a1 = pc + 16'd1;
    a2 = pc + 16'd2;
    r.opcode  = mem[pc];
    r.len     = len_ref(r.opcode);
    r.pc      = pc;
    r.operand = 16'h0000;
    if (r.len >= 2'd2) r.operand[7:0]  = mem[a1];
    if (r.len == 2'd3) r.operand[15:8] = mem[a2];
    return r;
  endfunction

  // Memory: request seen mid-cycle, rvalid driven for one cycle 'lat' cycles later.
  initial begin
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 8'h00;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        rsp_cnt = 0;
      end else if (mem_req_o) begin
        checks++;
        if (rsp_cnt != 0) begin
          failures++;
          $display("FAIL single_outstanding: new request at %h while %0d cycles still pending, required 0", mem_addr_o, rsp_cnt);
        end
        req_log.push_back(mem_addr_o);
        rsp_addr = mem_addr_o;
        rsp_cnt  = lat;
      end
      @(posedge clk_i);
      #1;
      mem_rvalid_i = 1'b0;
      if (rst_i) rsp_cnt = 0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = mem[rsp_addr];
        end
      end
    end
  end

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (instr_valid_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wait_valid: instr_valid_o=0 after 200 cycles, required 1");
      finish_run();
    end
  endtask

  task automatic sample(output fetch_instr_t g);
    g.opcode  = instr_opcode_o;
    g.operand = instr_operand_o;
    g.len     = instr_len_o;
    g.pc      = instr_pc_o;
  endtask

  task automatic accept();
    instr_ready_i = 1'b1;
    #1 req_log.delete();
    @(negedge clk_i);
    instr_ready_i = 1'b0;
  endtask

  task automatic redirect(input logic [15:0] pc);
    flush_i    = 1'b1;
    flush_pc_i = pc;
    #1 req_log.delete();
    @(negedge clk_i);
    flush_i = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk_i);
    #3 rst_i = 1'b0;
  endtask

  task automatic test_reset();
    fetch_instr_t got, exp;
    mem[16'hFFFC] = 8'hEA;
    mem[16'hFFFD] = 8'hEA;
    @(negedge clk_i);
    #1;
    checks++;
    if ({mem_req_o, mem_addr_o, instr_valid_o, instr_opcode_o, instr_operand_o, instr_len_o, instr_pc_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: req=%b addr=%h valid=%b op=%h opd=%h len=%0d pc=%h, required all 0",
               mem_req_o, mem_addr_o, instr_valid_o, instr_opcode_o, instr_operand_o, instr_len_o, instr_pc_o);
    end
    release_reset();
    @(negedge clk_i);
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 16'hFFFC) begin
      failures++;
      $display("FAIL boot_request: req=%b addr=%h, required req=1 addr=fffc", mem_req_o, mem_addr_o);
    end
    wait_valid();
    sample(got);
    exp = '{opcode: 8'hEA, operand: 16'h0000, len: 2'd1, pc: 16'hFFFC};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL boot_instr: got op=%h opd=%h len=%0d pc=%h, required op=ea opd=0000 len=1 pc=fffc",
               got.opcode, got.operand, got.len, got.pc);
    end
    accept();
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 16'hFFFD) begin
      failures++;
      $display("FAIL next_request: req=%b addr=%h, required req=1 addr=fffd", mem_req_o, mem_addr_o);
    end
  endtask

  task automatic test_two_byte();
    fetch_instr_t got, exp;
    mem[16'h8000] = 8'hA9;
    mem[16'h8001] = 8'h42;
    redirect(16'h8000);
    wait_valid();
    sample(got);
    exp = '{opcode: 8'hA9, operand: 16'h0042, len: 2'd2, pc: 16'h8000};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL two_byte_instr: got op=%h opd=%h len=%0d pc=%h, required op=a9 opd=0042 len=2 pc=8000",
               got.opcode, got.operand, got.len, got.pc);
    end
    checks++;
    if (req_log.size() != 2 || req_log[0] !== 16'h8000 || req_log[1] !== 16'h8001) begin
      failures++;
      $display("FAIL two_byte_requests: got %0d requests, required 8000,8001", req_log.size());
    end
    accept();
  endtask

  task automatic test_wrap();
    fetch_instr_t got, exp;
    mem[16'hFFFE] = 8'h4C;
    mem[16'hFFFF] = 8'h34;
    mem[16'h0000] = 8'h12;
    redirect(16'hFFFE);
    wait_valid();
    sample(got);
    exp = '{opcode: 8'h4C, operand: 16'h1234, len: 2'd3, pc: 16'hFFFE};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL wrap_instr: got op=%h opd=%h len=%0d pc=%h, required op=4c opd=1234 len=3 pc=fffe",
               got.opcode, got.operand, got.len, got.pc);
    end
    checks++;
    if (req_log.size() != 3 || req_log[0] !== 16'hFFFE || req_log[1] !== 16'hFFFF || req_log[2] !== 16'h0000) begin
      failures++;
      $display("FAIL wrap_requests: got %0d requests, required fffe,ffff,0000", req_log.size());
    end
    accept();
  endtask

  task automatic test_stall();
    fetch_instr_t first, got;
    mem[16'h8100] = 8'hAD;
    mem[16'h8101] = 8'h00;
    mem[16'h8102] = 8'h20;
    redirect(16'h8100);
    wait_valid();
    sample(first);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      sample(got);
      checks++;
      if (got !== first || instr_valid_o !== 1'b1 || mem_req_o !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold: cycle %0d valid=%b req=%b op=%h opd=%h, required valid=1 req=0 op=%h opd=%h",
                 i, instr_valid_o, mem_req_o, got.opcode, got.operand, first.opcode, first.operand);
      end
    end
    accept();
    checks++;
    if (instr_valid_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 16'h8103) begin
      failures++;
      $display("FAIL stall_release: valid=%b req=%b addr=%h, required valid=0 req=1 addr=8103",
               instr_valid_o, mem_req_o, mem_addr_o);
    end
  endtask

  task automatic test_flush_wait();
    fetch_instr_t got, exp;
    bit seen;
    mem[16'h9000] = 8'hAD;
    mem[16'h9001] = 8'h55;
    mem[16'h9002] = 8'h66;
    mem[16'hC000] = 8'hA9;
    mem[16'hC001] = 8'h77;
    lat = 3;
    redirect(16'h9000);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (mem_req_o && mem_addr_o == 16'h9000) seen = 1'b1;
      else @(negedge clk_i);
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL flush_wait_setup: no request at 9000 seen, required one");
    end
    @(negedge clk_i);
    redirect(16'hC000);
    wait_valid();
    sample(got);
    exp = '{opcode: 8'hA9, operand: 16'h0077, len: 2'd2, pc: 16'hC000};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL flush_wait_instr: got op=%h opd=%h len=%0d pc=%h, required op=a9 opd=0077 len=2 pc=c000",
               got.opcode, got.operand, got.len, got.pc);
    end
    checks++;
    if (req_log.size() != 2 || req_log[0] !== 16'hC000 || req_log[1] !== 16'hC001) begin
      failures++;
      $display("FAIL flush_wait_requests: got %0d requests, required c000,c001", req_log.size());
    end
    accept();
    lat = 1;
  endtask

  task automatic test_flush_out();
    fetch_instr_t got, exp;
    mem[16'hA000] = 8'hEA;
    mem[16'hD000] = 8'h20;
    mem[16'hD001] = 8'h34;
    mem[16'hD002] = 8'h12;
    redirect(16'hA000);
    wait_valid();
    instr_ready_i = 1'b1;
    redirect(16'hD000);
    instr_ready_i = 1'b0;
    checks++;
    if (instr_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL flush_out_drop: instr_valid_o=%b after flush, required 0", instr_valid_o);
    end
    wait_valid();
    sample(got);
    exp = '{opcode: 8'h20, operand: 16'h1234, len: 2'd3, pc: 16'hD000};
    checks++;
    if (got !== exp || req_log.size() == 0 || req_log[0] !== 16'hD000) begin
      failures++;
      $display("FAIL flush_out_resume: got op=%h opd=%h len=%0d pc=%h, required op=20 opd=1234 len=3 pc=d000 first req d000",
               got.opcode, got.operand, got.len, got.pc);
    end
    accept();
  endtask

  task automatic test_reset_mid();
    fetch_instr_t got, exp;
    mem[16'hE000] = 8'h4C;
    mem[16'hE001] = 8'h00;
    mem[16'hE002] = 8'h80;
    redirect(16'hE000);
    for (int i = 0; i < 30 && req_log.size() < 2; i++) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    checks++;
    if ({mem_req_o, mem_addr_o, instr_valid_o, instr_opcode_o, instr_operand_o, instr_len_o, instr_pc_o} !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs: req=%b addr=%h valid=%b op=%h opd=%h len=%0d pc=%h, required all 0",
               mem_req_o, mem_addr_o, instr_valid_o, instr_opcode_o, instr_operand_o, instr_len_o, instr_pc_o);
    end
    @(negedge clk_i);
    release_reset();
    @(negedge clk_i);
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 16'hFFFC) begin
      failures++;
      $display("FAIL reset_mid_restart: req=%b addr=%h, required req=1 addr=fffc", mem_req_o, mem_addr_o);
    end
    wait_valid();
    sample(got);
    exp = '{opcode: 8'hEA, operand: 16'h0000, len: 2'd1, pc: 16'hFFFC};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL reset_mid_instr: got op=%h opd=%h len=%0d pc=%h, required op=ea opd=0000 len=1 pc=fffc",
               got.opcode, got.operand, got.len, got.pc);
    end
    accept();
  endtask

  task automatic test_latency();
    fetch_instr_t got, exp;
    int idle;
    mem[16'hFFFC] = 8'h20;
    mem[16'hFFFD] = 8'hCD;
    mem[16'hFFFE] = 8'hAB;
    @(negedge clk_i);
    rst_i = 1'b1;
    release_reset();
    idle = 0;
    @(negedge clk_i);
    while (!instr_valid_o && idle < 50) begin
      idle++;
      @(negedge clk_i);
    end
    checks++;
    if (idle != 6) begin
      failures++;
      $display("FAIL latency_3byte: valid after %0d idle cycles, required 6", idle);
    end
    sample(got);
    exp = '{opcode: 8'h20, operand: 16'hABCD, len: 2'd3, pc: 16'hFFFC};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL latency_instr: got op=%h opd=%h len=%0d pc=%h, required op=20 opd=abcd len=3 pc=fffc",
               got.opcode, got.operand, got.len, got.pc);
    end
    accept();
  endtask

  task automatic test_random();
    fetch_instr_t got, exp;
    logic [15:0] exp_pc;
    for (int b = 0; b < 16; b++) begin
      lat = int'($urandom_range(1, 4));
      exp_pc = 16'($urandom);
      redirect(exp_pc);
      for (int k = 0; k < 6; k++) begin
        if (k > 0 && $urandom_range(0, 5) == 0) begin
          repeat ($urandom_range(0, 4)) @(negedge clk_i);
          exp_pc = 16'($urandom);
          redirect(exp_pc);
        end
        wait_valid();
        sample(got);
        exp = model_instr(exp_pc);
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL random_instr: got op=%h opd=%h len=%0d pc=%h, required op=%h opd=%h len=%0d pc=%h",
                   got.opcode, got.operand, got.len, got.pc, exp.opcode, exp.operand, exp.len, exp.pc);
        end
        checks++;
        if (req_log.size() != int'(exp.len)) begin
          failures++;
          $display("FAIL random_req_count: got %0d requests, required %0d", req_log.size(), exp.len);
        end else begin
          for (int j = 0; j < int'(exp.len); j++) begin
            checks++;
            if (req_log[j] !== exp.pc + 16'(j)) begin
              failures++;
              $display("FAIL random_req_addr: request %0d at %h, required %h", j, req_log[j], exp.pc + 16'(j));
            end
          end
        end
        $display("txn pc=%h op=%h len=%0d operand=%h lat=%0d", got.pc, got.opcode, got.len, got.operand, lat);
        repeat ($urandom_range(0, 2)) @(negedge clk_i);
        accept();
        exp_pc = exp.pc + 16'(exp.len);
      end
    end
    lat = 1;
  endtask

  initial begin
    rst_i         = 1'b1;
    flush_i       = 1'b0;
    flush_pc_i    = 16'h0000;
    instr_ready_i = 1'b0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    test_reset();
    test_two_byte();
    test_wrap();
    test_stall();
    test_flush_wait();
    test_flush_out();
    test_reset_mid();
    test_latency();
    test_random();
    finish_run();
  end

endmodule
